// File: rtl/ra_stack.sv
// ra_stack: return-address spill stack sitting in front of the register file RA port.
// A call saves the live RA and loads the link address; a return restores the saved RA.
module ra_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             call,
   input  logic             ret,
   input  logic [WIDTH-1:0] link_addr,
   input  logic [WIDTH-1:0] ra_cur,
   input  logic             clr_err,
   output logic [WIDTH-1:0] ra_din,
   output logic             ra_we,
   output logic [WIDTH-1:0] jump_addr,
   output logic             ret_valid,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W:0]   r_sp;
   logic             r_ovf;
   logic             r_unf;

   logic             w_full;
   logic             w_empty;
   logic             w_call_only;
   logic             w_ret_only;
   logic             w_tail;
   logic             w_push;
   logic             w_pop;
   logic             w_ovf_evt;
   logic             w_unf_evt;
   logic [PTR_W-1:0] w_wr_idx;
   logic [PTR_W-1:0] w_rd_idx;

   assign w_full      = (r_sp == LP_DEPTH);
   assign w_empty     = (r_sp == '0);
   assign w_call_only = call & ~ret;
   assign w_ret_only  = ret & ~call;
   assign w_tail      = call & ret;
   assign w_push      = w_call_only & ~w_full;
   assign w_pop       = w_ret_only & ~w_empty;
   assign w_ovf_evt   = w_call_only & w_full;
   assign w_unf_evt   = w_ret_only & w_empty;
   assign w_wr_idx    = r_sp[PTR_W-1:0];
   // When sp == DEPTH == 2^PTR_W the low bits wrap to 0, so sp-1 still lands on the top entry.
   assign w_rd_idx    = r_sp[PTR_W-1:0] - PTR_W'(1);

   always_comb begin
      ra_din = link_addr;
      if (w_ret_only) begin
         ra_din = r_mem[w_rd_idx];
      end
      ra_we     = ~reset & (w_push | w_pop | w_tail);
      jump_addr = ra_cur;
      ret_valid = ~reset & ret;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[w_wr_idx] <= ra_cur;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sp  <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_push) begin
            r_sp <= r_sp + 1'b1;
         end else if (w_pop) begin
            r_sp <= r_sp - 1'b1;
         end
         // An error event in the same cycle as clr_err keeps the flag set.
         r_ovf <= w_ovf_evt | (r_ovf & ~clr_err);
         r_unf <= w_unf_evt | (r_unf & ~clr_err);
      end
   end

   assign count     = r_sp;
   assign full      = w_full;
   assign empty     = w_empty;
   assign overflow  = r_ovf;
   assign underflow = r_unf;

endmodule
